// File: rtl/l1i_miss_handler.sv
// l1i_miss_handler: tracks one pending I-cache miss per thread, merges misses
// to the same line, fetches lines from L2 and fills the L1I tag/data arrays.
// Optional feature macro: L1I_MISS_PERF_EN (drives the perf event outputs).
// NUM_THREADS, L1I_WAYS and L1I_SETS are assumed to be powers of two.

module l1i_miss_entry #(
  parameter int NUM_THREADS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc,
  input  logic                   merge,
  input  logic                   issue,
  input  logic                   free,
  input  logic [31:0]            miss_addr,
  input  logic [NUM_THREADS-1:0] thread_oh,
  output logic                   valid,
  output logic                   issued,
  output logic [31:0]            addr,
  output logic [NUM_THREADS-1:0] bitmap
);
  // Entry state; free wins because a merge into the retiring entry is woken directly
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      issued <= 1'b0;
      addr   <= '0;
      bitmap <= '0;
    end else if (free) begin
      valid  <= 1'b0;
      issued <= 1'b0;
      bitmap <= '0;
    end else if (alloc) begin
      valid  <= 1'b1;
      issued <= 1'b0;
      addr   <= miss_addr;
      bitmap <= thread_oh;
    end else begin
      if (merge) bitmap <= bitmap | thread_oh;
      if (issue) issued <= 1'b1;
    end
  end
endmodule

module l1i_miss_handler #(
  parameter  int NUM_THREADS = 4,
  parameter  int L1I_WAYS    = 4,
  parameter  int L1I_SETS    = 64,
  localparam int TW          = $clog2(NUM_THREADS),
  localparam int WW          = $clog2(L1I_WAYS),
  localparam int SW          = $clog2(L1I_SETS),
  localparam int TAGW        = 26 - SW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifd_cache_miss,
  input  logic [31:0]            ifd_cache_miss_addr,
  input  logic [TW-1:0]          ifd_cache_miss_thread_idx,
  output logic                   l2_req_valid,
  output logic [31:0]            l2_req_addr,
  input  logic                   l2_req_ready,
  input  logic                   l2_rsp_valid,
  input  logic [31:0]            l2_rsp_addr,
  input  logic [511:0]           l2_rsp_data,
  output logic                   l2i_idata_update_en,
  output logic [WW-1:0]          l2i_idata_update_way,
  output logic [SW-1:0]          l2i_idata_update_set,
  output logic [511:0]           l2i_idata_update_data,
  output logic [L1I_WAYS-1:0]    l2i_itag_update_en_oh,
  output logic [SW-1:0]          l2i_itag_update_set,
  output logic [TAGW-1:0]        l2i_itag_update_tag,
  output logic [NUM_THREADS-1:0] l2i_icache_wake_bitmap,
  output logic                   perf_icache_fill,
  output logic                   perf_icache_miss_merged
);
  typedef struct packed {
    logic [TW-1:0]  idx;
    logic [25:0]    line;
    logic [511:0]   data;
  } rsp_t;

  logic [NUM_THREADS-1:0]                  ent_valid, ent_issued;
  logic [NUM_THREADS-1:0][31:0]            ent_addr;
  logic [NUM_THREADS-1:0][NUM_THREADS-1:0] ent_bitmap;
  logic [NUM_THREADS-1:0] hit_oh, rsp_oh, pend, alloc_oh, issue_oh, free_oh;
  logic [NUM_THREADS-1:0] thread_oh, late_oh;
  logic                   merge_hit, any_free;
  logic [TW-1:0]          rr_ptr, rr_grant, rr_cand, grant, lock_idx, rsp_idx;
  logic                   rr_found, lock_vld, handshake;
  logic                   rsp_take, rsp_vld_q;
  rsp_t                   rsp_q;
  logic [WW-1:0]          victim [L1I_SETS];
  logic [SW-1:0]          upd_set;
  logic [WW-1:0]          upd_way;

  assign thread_oh = NUM_THREADS'(1) << ifd_cache_miss_thread_idx;

  // Per-entry address compare for miss merge, fill lookup and issue eligibility
  always_comb begin
    hit_oh = '0;
    rsp_oh = '0;
    pend   = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      hit_oh[i] = ent_valid[i] && (ent_addr[i] == ifd_cache_miss_addr);
      rsp_oh[i] = ent_valid[i] && ent_issued[i] && (ent_addr[i] == l2_rsp_addr);
      pend[i]   = ent_valid[i] && !ent_issued[i];
    end
  end

  assign merge_hit = ifd_cache_miss && |hit_oh;
  assign any_free  = ~&ent_valid;

  // A miss that does not merge takes the lowest-index free entry
  always_comb begin
    alloc_oh = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--)
      if (!ent_valid[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    if (!ifd_cache_miss || merge_hit) alloc_oh = '0;
  end

  // Encode the entry matched by the incoming fill
  always_comb begin
    rsp_idx = '0;
    for (int i = 0; i < NUM_THREADS; i++)
      if (rsp_oh[i]) rsp_idx = TW'(i);
  end

  // A response matching no entry (e.g. issued before a reset) is dropped
  assign rsp_take = l2_rsp_valid && |rsp_oh;

  // Round-robin pick among unissued entries starting at the pointer
  always_comb begin
    rr_grant = rr_ptr;
    rr_found = 1'b0;
    rr_cand  = rr_ptr;
    for (int k = 0; k < NUM_THREADS; k++) begin
      rr_cand = rr_ptr + TW'(k);
      if (!rr_found && pend[rr_cand]) begin
        rr_found = 1'b1;
        rr_grant = rr_cand;
      end
    end
  end

  // A stalled request stays locked so its address cannot change under backpressure
  assign grant        = lock_vld ? lock_idx : rr_grant;
  assign l2_req_valid = lock_vld || rr_found;
  assign l2_req_addr  = l2_req_valid ? ent_addr[grant] : '0;
  assign handshake    = l2_req_valid && l2_req_ready;
  assign issue_oh     = handshake ? (NUM_THREADS'(1) << grant) : '0;

  // Issue pointer and stall lock
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (handshake) begin
      rr_ptr   <= grant + TW'(1);
      lock_vld <= 1'b0;
    end else if (l2_req_valid) begin
      lock_vld <= 1'b1;
      lock_idx <= grant;
    end
  end

  // Register the fill; the array update happens the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      rsp_vld_q <= rsp_take;
      if (rsp_take) rsp_q <= '{idx: rsp_idx, line: l2_rsp_addr[31:6], data: l2_rsp_data};
    end
  end

  assign upd_set = rsp_q.line[SW-1:0];
  assign upd_way = victim[upd_set];
  assign free_oh = rsp_vld_q ? (NUM_THREADS'(1) << rsp_q.idx) : '0;
  // A miss to the retiring line in the update cycle is woken instead of stored
  assign late_oh = (ifd_cache_miss && hit_oh[rsp_q.idx]) ? thread_oh : '0;

  assign l2i_idata_update_en    = rsp_vld_q;
  assign l2i_idata_update_way   = rsp_vld_q ? upd_way : '0;
  assign l2i_idata_update_set   = rsp_vld_q ? upd_set : '0;
  assign l2i_idata_update_data  = rsp_vld_q ? rsp_q.data : '0;
  assign l2i_itag_update_en_oh  = rsp_vld_q ? (L1I_WAYS'(1) << upd_way) : '0;
  assign l2i_itag_update_set    = rsp_vld_q ? upd_set : '0;
  assign l2i_itag_update_tag    = rsp_vld_q ? rsp_q.line[25 -: TAGW] : '0;
  assign l2i_icache_wake_bitmap = rsp_vld_q ? (ent_bitmap[rsp_q.idx] | late_oh) : '0;

  // Per-set victim way rotates on every fill to that set
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < L1I_SETS; s++) victim[s] <= '0;
    end else if (rsp_vld_q) begin
      victim[upd_set] <= upd_way + WW'(1);
    end
  end

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_ent
    l1i_miss_entry #(.NUM_THREADS(NUM_THREADS)) u_ent (
      .clk       (clk),
      .reset     (reset),
      .alloc     (alloc_oh[i]),
      .merge     (ifd_cache_miss && hit_oh[i]),
      .issue     (issue_oh[i]),
      .free      (free_oh[i]),
      .miss_addr (ifd_cache_miss_addr),
      .thread_oh (thread_oh),
      .valid     (ent_valid[i]),
      .issued    (ent_issued[i]),
      .addr      (ent_addr[i]),
      .bitmap    (ent_bitmap[i])
    );
  end

`ifdef L1I_MISS_PERF_EN
  assign perf_icache_fill        = rsp_vld_q;
  assign perf_icache_miss_merged = merge_hit;
`else
  assign perf_icache_fill        = 1'b0;
  assign perf_icache_miss_merged = 1'b0;
`endif

  // One outstanding miss per thread guarantees a free entry; fills match at most one entry
  a_alloc_free : assert property (@(posedge clk) disable iff (reset)
    (ifd_cache_miss && !merge_hit) |-> any_free);
  a_rsp_unique : assert property (@(posedge clk) disable iff (reset)
    l2_rsp_valid |-> $onehot0(rsp_oh));

endmodule

// File: tb/tb_l1i_miss_handler.sv
// Scoreboard bench for l1i_miss_handler: expected L2 requests and fill updates
// are queued when stimulus is driven and compared when the DUT produces them.

module tb_l1i_miss_handler;
  localparam int NT = 4;
  localparam int NW = 4;
  localparam int NS = 64;
`ifdef L1I_MISS_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         ifd_cache_miss;
  logic [31:0]  ifd_cache_miss_addr;
  logic [1:0]   ifd_cache_miss_thread_idx;
  logic         l2_req_valid;
  logic [31:0]  l2_req_addr;
  logic         l2_req_ready;
  logic         l2_rsp_valid;
  logic [31:0]  l2_rsp_addr;
  logic [511:0] l2_rsp_data;
  logic         l2i_idata_update_en;
  logic [1:0]   l2i_idata_update_way;
  logic [5:0]   l2i_idata_update_set;
  logic [511:0] l2i_idata_update_data;
  logic [3:0]   l2i_itag_update_en_oh;
  logic [5:0]   l2i_itag_update_set;
  logic [19:0]  l2i_itag_update_tag;
  logic [3:0]   l2i_icache_wake_bitmap;
  logic         perf_icache_fill;
  logic         perf_icache_miss_merged;

  l1i_miss_handler #(.NUM_THREADS(NT), .L1I_WAYS(NW), .L1I_SETS(NS)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .ifd_cache_miss            (ifd_cache_miss),
    .ifd_cache_miss_addr       (ifd_cache_miss_addr),
    .ifd_cache_miss_thread_idx (ifd_cache_miss_thread_idx),
    .l2_req_valid              (l2_req_valid),
    .l2_req_addr               (l2_req_addr),
    .l2_req_ready              (l2_req_ready),
    .l2_rsp_valid              (l2_rsp_valid),
    .l2_rsp_addr               (l2_rsp_addr),
    .l2_rsp_data               (l2_rsp_data),
    .l2i_idata_update_en       (l2i_idata_update_en),
    .l2i_idata_update_way      (l2i_idata_update_way),
    .l2i_idata_update_set      (l2i_idata_update_set),
    .l2i_idata_update_data     (l2i_idata_update_data),
    .l2i_itag_update_en_oh     (l2i_itag_update_en_oh),
    .l2i_itag_update_set       (l2i_itag_update_set),
    .l2i_itag_update_tag       (l2i_itag_update_tag),
    .l2i_icache_wake_bitmap    (l2i_icache_wake_bitmap),
    .perf_icache_fill          (perf_icache_fill),
    .perf_icache_miss_merged   (perf_icache_miss_merged)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   oh;
    logic [5:0]   set;
    logic [19:0]  tag;
    logic [1:0]   way;
    logic [511:0] data;
    logic [3:0]   wake;
  } upd_t;

  upd_t        upd_q[$];
  logic [31:0] req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vict[NS];
  upd_t        mu;
  logic [31:0] mreq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifd_cache_miss = 1'b0;
    l2_rsp_valid   = 1'b0;
  endtask

  task automatic clear_victims();
    for (int s = 0; s < NS; s++) vict[s] = 0;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_miss(input int t, input logic [31:0] a);
    ifd_cache_miss            = 1'b1;
    ifd_cache_miss_addr       = a;
    ifd_cache_miss_thread_idx = 2'(t);
  endtask

  // Drive a fill and queue the array update it must produce one cycle later
  task automatic drive_rsp(input logic [31:0] a, input logic [511:0] d, input logic [3:0] wake);
    upd_t u;
    l2_rsp_valid = 1'b1;
    l2_rsp_addr  = a;
    l2_rsp_data  = d;
    u.set  = a[11:6];
    u.tag  = a[31:12];
    u.way  = 2'(vict[a[11:6]]);
    u.oh   = 4'b0001 << u.way;
    u.data = d;
    u.wake = wake;
    vict[a[11:6]] = (vict[a[11:6]] + 1) % NW;
    upd_q.push_back(u);
  endtask

  // Scoreboard: every request handshake and every update pulse is compared
  always @(negedge clk) begin
    if (l2_req_valid && l2_req_ready) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got addr %h, none expected", l2_req_addr);
      end else begin
        mreq = req_q.pop_front();
        if (l2_req_addr !== mreq) begin
          errors++;
          $display("FAIL req_addr: got %h, expected %h", l2_req_addr, mreq);
        end
      end
    end
    if (l2i_idata_update_en || l2i_itag_update_en_oh != 4'd0 || l2i_icache_wake_bitmap != 4'd0) begin
      checks++;
      if (upd_q.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected: got en %b oh %b wake %b, none expected",
                 l2i_idata_update_en, l2i_itag_update_en_oh, l2i_icache_wake_bitmap);
      end else begin
        mu = upd_q.pop_front();
        if ({l2i_idata_update_en, l2i_itag_update_en_oh, l2i_itag_update_set, l2i_itag_update_tag,
             l2i_idata_update_way, l2i_idata_update_set, l2i_icache_wake_bitmap, perf_icache_fill} !==
            {1'b1, mu.oh, mu.set, mu.tag, mu.way, mu.set, mu.wake, PERF}) begin
          errors++;
          $display("FAIL upd_fields: got en %b oh %b set %0d tag %h way %0d dset %0d wake %b pf %b, expected oh %b set %0d tag %h way %0d wake %b pf %b",
                   l2i_idata_update_en, l2i_itag_update_en_oh, l2i_itag_update_set, l2i_itag_update_tag,
                   l2i_idata_update_way, l2i_idata_update_set, l2i_icache_wake_bitmap, perf_icache_fill,
                   mu.oh, mu.set, mu.tag, mu.way, mu.wake, PERF);
        end
        checks++;
        if (l2i_idata_update_data !== mu.data) begin
          errors++;
          $display("FAIL upd_data: got %h, expected %h", l2i_idata_update_data, mu.data);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    idle();
    l2_req_ready = 1'b0;
    ifd_cache_miss_addr = '0;
    ifd_cache_miss_thread_idx = '0;
    l2_rsp_addr = '0;
    l2_rsp_data = '0;
    clear_victims();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 1'b0 || l2_req_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_req: got valid %b addr %h, expected 0/0", l2_req_valid, l2_req_addr);
    end
    checks++;
    if (l2i_idata_update_en !== 1'b0 || l2i_itag_update_en_oh !== 4'd0 || l2i_icache_wake_bitmap !== 4'd0) begin
      errors++;
      $display("FAIL reset_upd: got en %b oh %b wake %b, expected all 0",
               l2i_idata_update_en, l2i_itag_update_en_oh, l2i_icache_wake_bitmap);
    end
    checks++;
    if (perf_icache_fill !== 1'b0 || perf_icache_miss_merged !== 1'b0) begin
      errors++;
      $display("FAIL reset_perf: got %b%b, expected 00", perf_icache_fill, perf_icache_miss_merged);
    end
  endtask

  task automatic test_single_miss();
    l2_req_ready = 1'b1;
    tick();
    drive_miss(1, 32'h0000_1040);
    req_q.push_back(32'h0000_1040);
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 1'b1 || l2_req_addr !== 32'h0000_1040) begin
      errors++;
      $display("FAIL single_req_latency: got valid %b addr %h, expected 1/00001040", l2_req_valid, l2_req_addr);
    end
    tick();
    drive_rsp(32'h0000_1040, rnd512(), 4'b0010);
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (l2i_idata_update_en !== 1'b1) begin
      errors++;
      $display("FAIL single_fill_latency: got en %b, expected 1", l2i_idata_update_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (l2i_idata_update_en !== 1'b0) begin
      errors++;
      $display("FAIL single_fill_pulse: got en %b, expected 0", l2i_idata_update_en);
    end
    tick();
  endtask

  task automatic test_merge();
    drive_miss(0, 32'h0000_2000);
    req_q.push_back(32'h0000_2000);
    tick();
    drive_miss(2, 32'h0000_2000);
    @(negedge clk);
    checks++;
    if (perf_icache_miss_merged !== PERF) begin
      errors++;
      $display("FAIL merge_perf: got %b, expected %b", perf_icache_miss_merged, PERF);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (perf_icache_miss_merged !== 1'b0) begin
      errors++;
      $display("FAIL merge_perf_once: got %b, expected 0", perf_icache_miss_merged);
    end
    tick();
    drive_rsp(32'h0000_2000, rnd512(), 4'b0101);
    tick();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a [4];
    a = '{32'h0001_0000, 32'h0002_0040, 32'h0003_0080, 32'h0004_0100};
    l2_req_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c < 4) begin
        drive_miss(c, a[c]);
        req_q.push_back(a[c]);
      end else begin
        idle();
      end
      if (c >= 1) begin
        @(negedge clk);
        checks++;
        if (l2_req_valid !== 1'b1 || l2_req_addr !== a[0]) begin
          errors++;
          $display("FAIL bp_hold c=%0d: got valid %b addr %h, expected 1/%h", c, l2_req_valid, l2_req_addr, a[0]);
        end
      end
      tick();
    end
    l2_req_ready = 1'b1;
    repeat (6) tick();
    // Back-to-back fills, one per cycle
    for (int c = 0; c < 4; c++) begin
      drive_rsp(a[c], rnd512(), 4'b0001 << c);
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_victim();
    logic [31:0] ln [5];
    for (int k = 0; k < 5; k++) ln[k] = ((k + 1) << 12) | (3 << 6);
    drive_miss(0, ln[0]);
    req_q.push_back(ln[0]);
    tick();
    idle();
    tick();
    // Each fill is driven alongside the next miss to a different line
    for (int k = 0; k < 5; k++) begin
      drive_rsp(ln[k], rnd512(), 4'b0001 << (k % 2));
      if (k < 4) begin
        drive_miss((k + 1) % 2, ln[k+1]);
        req_q.push_back(ln[k+1]);
      end
      tick();
      idle();
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_late_merge();
    drive_miss(0, 32'h0000_5000);
    req_q.push_back(32'h0000_5000);
    tick();
    idle();
    tick();
    drive_rsp(32'h0000_5000, rnd512(), 4'b1001);
    tick();
    idle();
    drive_miss(3, 32'h0000_5000);
    @(negedge clk);
    checks++;
    if (perf_icache_miss_merged !== PERF) begin
      errors++;
      $display("FAIL late_merge_perf: got %b, expected %b", perf_icache_miss_merged, PERF);
    end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (l2_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL late_merge_noreq c=%0d: got valid %b addr %h, expected 0", c, l2_req_valid, l2_req_addr);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive_miss(0, 32'h0000_6000);
    req_q.push_back(32'h0000_6000);
    tick();
    drive_miss(1, 32'h0000_7040);
    req_q.push_back(32'h0000_7040);
    tick();
    idle();
    repeat (2) tick();
    // Reset in the same cycle as a valid fill: the fill must be dropped
    reset = 1'b1;
    l2_rsp_valid = 1'b1;
    l2_rsp_addr  = 32'h0000_6000;
    l2_rsp_data  = rnd512();
    clear_victims();
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 1'b0 || l2i_idata_update_en !== 1'b0 || l2i_itag_update_en_oh !== 4'd0 ||
        l2i_icache_wake_bitmap !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got req %b en %b oh %b wake %b, expected all 0",
               l2_req_valid, l2i_idata_update_en, l2i_itag_update_en_oh, l2i_icache_wake_bitmap);
    end
    reset = 1'b0;
    tick();
    l2_rsp_valid = 1'b1;
    l2_rsp_addr  = 32'h0000_7040;
    l2_rsp_data  = rnd512();
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (l2i_idata_update_en !== 1'b0 || l2i_icache_wake_bitmap !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_stray: got en %b wake %b, expected 0/0", l2i_idata_update_en, l2i_icache_wake_bitmap);
    end
    tick();
    drive_miss(2, 32'h0000_8000);
    req_q.push_back(32'h0000_8000);
    tick();
    idle();
    tick();
    drive_rsp(32'h0000_8000, rnd512(), 4'b0100);
    tick();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_miss();
    test_merge();
    test_backpressure();
    test_victim();
    test_late_merge();
    test_reset_mid();
    checks++;
    if (req_q.size() != 0 || upd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d requests and %0d updates outstanding, expected 0/0", req_q.size(), upd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1i_miss_handler.md
# l1i_miss_handler

Services instruction-cache misses reported by the ifetch data stage and produces the L1I tag/data fill traffic that stage consumes. It holds one pending-miss entry per thread, merges misses to the same line, issues line reads to the L2 request port, writes the returned line into the L1I tag and data arrays, and wakes every thread waiting on that line. It sits inside l2_interface, between the ifetch pipeline and the L2 cache.

## Interface
- NUM_THREADS, 4, hardware threads; also the number of pending-miss entries.
- L1I_WAYS, 4, instruction cache ways.
- L1I_SETS, 64, instruction cache sets; L1I_WAYS and L1I_SETS are powers of two.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- ifd_cache_miss  in  1  miss request valid this cycle.
- ifd_cache_miss_addr  in  32  line-aligned miss address, {tag, set, 6'b0}.
- ifd_cache_miss_thread_idx  in  log2(NUM_THREADS)  requesting thread.
- l2_req_valid  out  1  line read request valid.
- l2_req_addr  out  32  line address of request.
- l2_req_ready  in  1  L2 accepts request when valid && ready.
- l2_rsp_valid  in  1  fill response valid; no backpressure.
- l2_rsp_addr  in  32  line address of response.
- l2_rsp_data  in  512  line data.
- l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, l2i_idata_update_data  out  1/log2(WAYS)/log2(SETS)/512  data array write.
- l2i_itag_update_en_oh, l2i_itag_update_set, l2i_itag_update_tag  out  WAYS/log2(SETS)/26-log2(SETS)  tag array write, one-hot way.
- l2i_icache_wake_bitmap  out  NUM_THREADS  threads to resume, one-cycle pulse.
- perf_icache_fill, perf_icache_miss_merged  out  1  performance event pulses.

## Operation
- Entry fields: valid, issued, line address, waiting-thread bitmap.
- Miss intake: if ifd_cache_miss and a valid entry matches the address, OR the thread bit into its bitmap (merge) and do not allocate. Otherwise allocate the lowest-index free entry with bitmap = one-hot(thread), issued = 0. A free entry always exists (one outstanding miss per thread); allocating with none free is an assertion failure.
- Issue: round-robin among valid && !issued entries; pointer advances past the granted entry on handshake. l2_req_addr is stable while l2_req_valid is high and not accepted. On handshake, issued = 1.
- Fill: l2_rsp_valid must match exactly one valid issued entry (assertion). The response is registered. On the following cycle the block asserts the tag write (en_oh = victim way, set/tag from address), the data write (same way/set, registered data), wake_bitmap = entry bitmap, and frees the entry.
- Victim: per-set log2(WAYS)-bit round-robin pointer, reset 0, incremented modulo WAYS on each fill to that set.
- Merge into retiring entry: a matching miss in the response-register cycle, or in the update cycle, is ORed into the bitmap being woken. It is not allocated.
- Only one fill is processed per cycle. A back-to-back response is accepted while the prior update drives its outputs.

## Timing
- Reset: all entries invalid, the issue pointer and victim pointers 0, and every output 0.
- Miss to l2_req_valid: 1 cycle minimum (the entry is written at the edge, then requested).
- l2_rsp_valid to tag/data/wake outputs: exactly 1 cycle. All three assert in the same cycle for a single cycle.
- A miss and a fill in the same cycle to different lines are both handled with no stall.
- Reset asserted mid-operation discards all pending entries and any registered response. Outputs are 0 on the next cycle.

## Configuration
- L1I_MISS_PERF_EN defined: perf_icache_fill pulses with each tag write. perf_icache_miss_merged pulses on each miss that merges rather than allocates.
- L1I_MISS_PERF_EN undefined: both outputs are tied to 0 and the comparison logic feeding them is removed. No other behaviour changes.

## Test plan
- Single miss: thread 1 misses at 0x00001040 with ready=1 -> next cycle request 0x00001040. Respond with data D. One cycle later: tag write en_oh=0001, set 1, tag 0x00001040>>12. Data write way 0, set 1, D. wake_bitmap=0010.
- Merge: threads 0 and 2 miss at 0x2000 on consecutive cycles -> exactly one L2 request. The fill wakes 0101. perf_icache_miss_merged pulses once (PERF_EN).
- Backpressure/round-robin: 4 threads miss at distinct lines with ready=0 for 10 cycles -> l2_req_addr holds. After ready=1, requests go out in entry order 0,1,2,3.
- Victim rotation: 5 fills to set 3 -> en_oh sequence 0001, 0010, 0100, 1000, 0001.
- Late merge: thread 3 misses at line L in the cycle after L's response -> no new entry and no request. wake_bitmap includes bit 3.
- Reset mid-flight: reset while 2 entries are issued -> outputs 0. A later stray response is ignored, and a new miss allocates entry 0.
